// File: rtl/branch_pkg.sv
// Shared types and constants for the branch issue unit.
// Optional build macro BRANCH_STATS_EN enables branch outcome counters.
package branch_pkg;

    localparam int LUT_DEPTH = 32;
    localparam int TGT_W     = 16;
    localparam int IDX_W     = $clog2(LUT_DEPTH);
    localparam int OP_W      = 4;
    localparam int INSTR_W   = OP_W + IDX_W;
    localparam int CNT_W     = 16;

    typedef enum logic [OP_W-1:0] {
        OP_BZ   = 4'hC,
        OP_BNZ  = 4'hD,
        OP_BRA  = 4'hE,
        OP_HALT = 4'hF
    } opcode_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        HALTED = 2'd2
    } state_t;

    typedef struct packed {
        logic br_abs;
        logic br_z;
        logic br_nz;
        logic halt;
    } dec_t;

    function automatic logic [CNT_W-1:0] sat_inc(
        input logic [CNT_W-1:0] v
    );
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/branch_issuer_target_lut.sv
// Branch target table: one synchronous write port, one
// asynchronous read port, cleared by the asynchronous reset.
module target_lut
    import branch_pkg::*;
(
    input  logic             CLK,
    input  logic             Init_n,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [TGT_W-1:0] wdata,
    input  logic [IDX_W-1:0] raddr,
    output logic [TGT_W-1:0] rdata
);

    logic [TGT_W-1:0] mem [LUT_DEPTH];

    always_ff @(posedge CLK or negedge Init_n) begin
        if (!Init_n) begin
            for (int i = 0; i < LUT_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read sees the pre-write entry when the same index is written this cycle
    assign rdata = mem[raddr];

endmodule

// File: rtl/branch_issuer.sv
// Branch issue unit: decodes branch/halt opcodes and pulses the fetch redirect.
// Build macro BRANCH_STATS_EN adds taken_cnt / not_taken_cnt outputs.
module branch_issuer
    import branch_pkg::*;
(
    input  logic               CLK,
    input  logic               Init_n,
    input  logic               instr_valid,
    input  logic [INSTR_W-1:0] instr,
    input  logic               flag_we,
    input  logic               alu_zero_in,
    input  logic               lut_we,
    input  logic [IDX_W-1:0]   lut_addr,
    input  logic [TGT_W-1:0]   lut_data,
    output logic               Branch_abs,
    output logic               Branch_rel_z,
    output logic               Branch_rel_nz,
    output logic [TGT_W-1:0]   Target,
    output logic               ALU_zero,
`ifdef BRANCH_STATS_EN
    output logic [CNT_W-1:0]   taken_cnt,
    output logic [CNT_W-1:0]   not_taken_cnt,
`endif
    output logic               flush,
    output logic               DONE
);

    state_t           state_q;
    state_t           state_d;
    logic [OP_W-1:0]  op;
    logic [IDX_W-1:0] idx;
    logic [TGT_W-1:0] lut_rd;
    dec_t             dec;
    logic             decode_en;
    logic             take_abs;
    logic             take_z;
    logic             take_nz;
    logic             take_any;
    logic             is_branch;
    logic             zero_q;

    assign op  = instr[INSTR_W-1:IDX_W];
    assign idx = instr[IDX_W-1:0];

    target_lut u_lut (
        .CLK    (CLK),
        .Init_n (Init_n),
        .we     (lut_we),
        .waddr  (lut_addr),
        .wdata  (lut_data),
        .raddr  (idx),
        .rdata  (lut_rd)
    );

    always_comb begin
        dec = '0;
        unique case (1'b1)
            (op == OP_BRA):  dec.br_abs = 1'b1;
            (op == OP_BZ):   dec.br_z   = 1'b1;
            (op == OP_BNZ):  dec.br_nz  = 1'b1;
            (op == OP_HALT): dec.halt   = 1'b1;
            default:         dec        = '0;
        endcase
    end

    // Only a real instruction in IDLE is decoded; ISSUE holds the shadow slot
    assign decode_en = instr_valid && (state_q == IDLE);
    assign is_branch = dec.br_abs | dec.br_z | dec.br_nz;

    assign take_abs = decode_en & dec.br_abs;
    assign take_z   = decode_en & dec.br_z  &  zero_q;
    assign take_nz  = decode_en & dec.br_nz & ~zero_q;
    assign take_any = take_abs | take_z | take_nz;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (take_any) begin
                    state_d = ISSUE;
                end else if (decode_en && dec.halt) begin
                    state_d = HALTED;
                end
            end
            ISSUE:   state_d = IDLE;
            HALTED:  state_d = HALTED;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge Init_n) begin
        if (!Init_n) begin
            state_q       <= IDLE;
            Branch_abs    <= 1'b0;
            Branch_rel_z  <= 1'b0;
            Branch_rel_nz <= 1'b0;
            Target        <= '0;
            flush         <= 1'b0;
            zero_q        <= 1'b0;
            DONE          <= 1'b0;
        end else begin
            state_q       <= state_d;
            Branch_abs    <= take_abs;
            Branch_rel_z  <= take_z;
            Branch_rel_nz <= take_nz;
            Target        <= take_any ? lut_rd : '0;
            flush         <= take_any;
            if (flag_we && state_q != HALTED) begin
                zero_q <= alu_zero_in;
            end
            if (state_d == HALTED) begin
                DONE <= 1'b1;
            end
        end
    end

    assign ALU_zero = zero_q;

`ifdef BRANCH_STATS_EN
    always_ff @(posedge CLK or negedge Init_n) begin
        if (!Init_n) begin
            taken_cnt     <= '0;
            not_taken_cnt <= '0;
        end else if (decode_en && is_branch) begin
            if (take_any) begin
                taken_cnt <= sat_inc(taken_cnt);
            end else begin
                not_taken_cnt <= sat_inc(not_taken_cnt);
            end
        end
    end
`else
    logic unused_stats;
    assign unused_stats = is_branch;
`endif

endmodule

// File: tb/tb_branch_issuer.sv
// Directed table-driven bench for branch_issuer.
module tb_branch_issuer;

    logic        CLK = 1'b0;
    logic        Init_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic [8:0]  instr = '0;
    logic        flag_we = 1'b0;
    logic        alu_zero_in = 1'b0;
    logic        lut_we = 1'b0;
    logic [4:0]  lut_addr = '0;
    logic [15:0] lut_data = '0;
    logic        Branch_abs;
    logic        Branch_rel_z;
    logic        Branch_rel_nz;
    logic [15:0] Target;
    logic        ALU_zero;
    logic        flush;
    logic        DONE;
`ifdef BRANCH_STATS_EN
    logic [15:0] taken_cnt;
    logic [15:0] not_taken_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 CLK = ~CLK;

    branch_issuer dut (
        .CLK           (CLK),
        .Init_n        (Init_n),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .flag_we       (flag_we),
        .alu_zero_in   (alu_zero_in),
        .lut_we        (lut_we),
        .lut_addr      (lut_addr),
        .lut_data      (lut_data),
        .Branch_abs    (Branch_abs),
        .Branch_rel_z  (Branch_rel_z),
        .Branch_rel_nz (Branch_rel_nz),
        .Target        (Target),
        .ALU_zero      (ALU_zero),
`ifdef BRANCH_STATS_EN
        .taken_cnt     (taken_cnt),
        .not_taken_cnt (not_taken_cnt),
`endif
        .flush         (flush),
        .DONE          (DONE)
    );

    typedef struct {
        logic        v;
        logic [8:0]  ins;
        logic        fwe;
        logic        az;
        logic        lwe;
        logic [4:0]  la;
        logic [15:0] ld;
        logic [21:0] exp;
    } vec_t;

    localparam logic [3:0] BZ   = 4'hC;
    localparam logic [3:0] BNZ  = 4'hD;
    localparam logic [3:0] BRA  = 4'hE;
    localparam logic [3:0] HALT = 4'hF;

    vec_t tbl [23];

    function automatic logic [21:0] ex(
        input logic a, input logic rz, input logic rnz,
        input logic [15:0] t, input logic z,
        input logic f, input logic d
    );
        return {a, rz, rnz, t, z, f, d};
    endfunction

    function automatic vec_t mk(
        input logic v, input logic [3:0] op, input logic [4:0] ix,
        input logic fwe, input logic az,
        input logic lwe, input logic [4:0] la, input logic [15:0] ld,
        input logic [21:0] e
    );
        vec_t r;
        r.v = v; r.ins = {op, ix};
        r.fwe = fwe; r.az = az;
        r.lwe = lwe; r.la = la; r.ld = ld;
        r.exp = e;
        return r;
    endfunction

    function automatic logic [21:0] got();
        return {Branch_abs, Branch_rel_z, Branch_rel_nz,
                Target, ALU_zero, flush, DONE};
    endfunction

    task automatic check(input string name, input logic [21:0] want);
        logic [21:0] g;
        g = got();
        n_cmp++;
        if (g !== want) begin
            n_bad++;
            $display("FAIL %s got abs/rz/rnz=%b%b%b tgt=%h z=%b fl=%b dn=%b want abs/rz/rnz=%b%b%b tgt=%h z=%b fl=%b dn=%b",
                name, g[21], g[20], g[19], g[18:3], g[2], g[1], g[0],
                want[21], want[20], want[19], want[18:3], want[2], want[1], want[0]);
        end
    endtask

    task automatic drive(input vec_t r);
        instr_valid = r.v;
        instr       = r.ins;
        flag_we     = r.fwe;
        alu_zero_in = r.az;
        lut_we      = r.lwe;
        lut_addr    = r.la;
        lut_data    = r.ld;
    endtask

    task automatic idle_inputs();
        instr_valid = 0; instr = '0; flag_we = 0;
        alu_zero_in = 0; lut_we = 0; lut_addr = '0; lut_data = '0;
    endtask

    initial begin
        tbl[0]  = mk(0, 4'h0, 5'd0, 0, 0, 1, 5'd3, 16'h0040, ex(0,0,0,16'h0000,0,0,0));
        tbl[1]  = mk(1, BRA,  5'd3, 0, 0, 0, 5'd0, 16'h0000, ex(1,0,0,16'h0040,0,1,0));
        tbl[2]  = mk(1, BRA,  5'd3, 0, 0, 0, 5'd0, 16'h0000, ex(0,0,0,16'h0000,0,0,0));
        tbl[3]  = mk(0, 4'h0, 5'd0, 0, 0, 0, 5'd0, 16'h0000, ex(0,0,0,16'h0000,0,0,0));
        tbl[4]  = mk(0, 4'h0, 5'd0, 1, 1, 0, 5'd0, 16'h0000, ex(0,0,0,16'h0000,1,0,0));
        tbl[5]  = mk(1, BZ,   5'd3, 0, 0, 0, 5'd0, 16'h0000, ex(0,1,0,16'h0040,1,1,0));
        tbl[6]  = mk(0, 4'h0, 5'd0, 0, 0, 0, 5'd0, 16'h0000, ex(0,0,0,16'h0000,1,0,0));
        tbl[7]  = mk(1, BNZ,  5'd3, 0, 0, 0, 5'd0, 16'h0000, ex(0,0,0,16'h0000,1,0,0));
        tbl[8]  = mk(0, 4'h0, 5'd0, 1, 0, 0, 5'd0, 16'h0000, ex(0,0,0,16'h0000,0,0,0));
        tbl[9]  = mk(1, BZ,   5'd3, 1, 1, 0, 5'd0, 16'h0000, ex(0,0,0,16'h0000,1,0,0));
        tbl[10] = mk(1, BNZ,  5'd3, 0, 0, 0, 5'd0, 16'h0000, ex(0,0,0,16'h0000,1,0,0));
        tbl[11] = mk(0, 4'h0, 5'd0, 1, 0, 0, 5'd0, 16'h0000, ex(0,0,0,16'h0000,0,0,0));
        tbl[12] = mk(1, BNZ,  5'd3, 0, 0, 0, 5'd0, 16'h0000, ex(0,0,1,16'h0040,0,1,0));
        tbl[13] = mk(1, HALT, 5'd0, 1, 1, 0, 5'd0, 16'h0000, ex(0,0,0,16'h0000,1,0,0));
        tbl[14] = mk(1, BRA,  5'd5, 0, 0, 1, 5'd5, 16'h1234, ex(1,0,0,16'h0000,1,1,0));
        tbl[15] = mk(0, 4'h0, 5'd0, 0, 0, 0, 5'd0, 16'h0000, ex(0,0,0,16'h0000,1,0,0));
        tbl[16] = mk(1, BRA,  5'd5, 0, 0, 0, 5'd0, 16'h0000, ex(1,0,0,16'h1234,1,1,0));
        tbl[17] = mk(0, 4'h0, 5'd0, 0, 0, 0, 5'd0, 16'h0000, ex(0,0,0,16'h0000,1,0,0));
        tbl[18] = mk(0, BRA,  5'd3, 0, 0, 0, 5'd0, 16'h0000, ex(0,0,0,16'h0000,1,0,0));
        tbl[19] = mk(1, 4'h3, 5'd3, 0, 0, 0, 5'd0, 16'h0000, ex(0,0,0,16'h0000,1,0,0));
        tbl[20] = mk(1, HALT, 5'd0, 0, 0, 0, 5'd0, 16'h0000, ex(0,0,0,16'h0000,1,0,1));
        tbl[21] = mk(1, BRA,  5'd3, 1, 0, 0, 5'd0, 16'h0000, ex(0,0,0,16'h0000,1,0,1));
        tbl[22] = mk(0, 4'h0, 5'd0, 1, 0, 0, 5'd0, 16'h0000, ex(0,0,0,16'h0000,1,0,1));

        #3;
        check("reset_state", ex(0,0,0,16'h0000,0,0,0));
        @(negedge CLK);
        Init_n = 1'b1;

        for (int i = 0; i < 23; i++) begin
            drive(tbl[i]);
            @(negedge CLK);
            check($sformatf("row%0d", i), tbl[i].exp);
        end

        // Reset clears the sticky halt and flag immediately
        idle_inputs();
        Init_n = 1'b0;
        #1;
        check("reset_after_halt", ex(0,0,0,16'h0000,0,0,0));
        @(negedge CLK);
        Init_n = 1'b1;

        lut_we = 1; lut_addr = 5'd7; lut_data = 16'hBEEF;
        @(negedge CLK);
        idle_inputs();
        instr_valid = 1; instr = {BRA, 5'd7};
        @(posedge CLK);
        #1;
        check("issue_before_reset", ex(1,0,0,16'hBEEF,0,1,0));
        Init_n = 1'b0;
        #1;
        check("reset_mid_issue", ex(0,0,0,16'h0000,0,0,0));
        @(negedge CLK);
        Init_n = 1'b1;
        instr_valid = 1; instr = {BRA, 5'd7};
        @(negedge CLK);
        check("lut_cleared", ex(1,0,0,16'h0000,0,1,0));
        idle_inputs();
        @(negedge CLK);
        check("pulse_one_cycle", ex(0,0,0,16'h0000,0,0,0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
